// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command sequencer.
// Holds ASCII codes, FSM state encoding, range limits and the byte decoder.
package uart_cmd_pkg;

    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_S  = 8'h73;
    localparam logic [7:0] CH_C  = 8'h63;
    localparam logic [7:0] CH_M  = 8'h6d;
    localparam logic [7:0] CH_D  = 8'h64;
    localparam logic [7:0] CH_SU = 8'h53;
    localparam logic [7:0] CH_MU = 8'h4d;
    localparam logic [7:0] CH_HU = 8'h48;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_EXEC      = 3'd2;
    localparam logic [2:0] S_SET_WAIT  = 3'd3;
    localparam logic [2:0] S_SET_FETCH = 3'd4;
    localparam logic [2:0] S_SET_CHECK = 3'd5;

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_FETCH     = S_FETCH,
        ST_EXEC      = S_EXEC,
        ST_SET_WAIT  = S_SET_WAIT,
        ST_SET_FETCH = S_SET_FETCH,
        ST_SET_CHECK = S_SET_CHECK
    } state_e;

    typedef struct packed {
        logic run;
        logic stop;
        logic clear;
        logic mode;
        logic disp;
        logic sec_plus;
        logic min_plus;
        logic hour_plus;
    } cmd_pulse_t;

    // One-hot decode of a single-character command; all zero if unknown.
    function automatic cmd_pulse_t decode_cmd(input logic [7:0] b);
        cmd_pulse_t c;
        c = '0;
        case (b)
            CH_R:    c.run       = 1'b1;
            CH_S:    c.stop      = 1'b1;
            CH_C:    c.clear     = 1'b1;
            CH_M:    c.mode      = 1'b1;
            CH_D:    c.disp      = 1'b1;
            CH_SU:   c.sec_plus  = 1'b1;
            CH_MU:   c.min_plus  = 1'b1;
            CH_HU:   c.hour_plus = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// RX FIFO read port between the FIFO and the command sequencer.
// master: sequencer (issues rx_pop); slave: FIFO (drives rx_empty/rx_data).
interface uart_cmd_sequencer_if;

    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_pop;

    modport master (
        input  rx_empty,
        input  rx_data,
        output rx_pop
    );

    modport slave (
        output rx_empty,
        output rx_data,
        input  rx_pop
    );

endinterface

// File: rtl/uart_cmd_sequencer_set_time_checker.sv
// Combinational hhmmss assembler and range check for the set-time command.
// In: six BCD digits (d0 = hour tens). Out: hour/min/sec and in-range flag.
module set_time_checker
    import uart_cmd_pkg::*;
(
    input  logic [5:0][3:0] i_digits,
    output logic [4:0]      o_hour,
    output logic [5:0]      o_min,
    output logic [5:0]      o_sec,
    output logic            o_ok
);

    logic [6:0] hour7;
    logic [6:0] min7;
    logic [6:0] sec7;

    function automatic logic [6:0] two_digit(
        input logic [3:0] tens,
        input logic [3:0] units
    );
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

    always_comb begin
        hour7  = two_digit(i_digits[0], i_digits[1]);
        min7   = two_digit(i_digits[2], i_digits[3]);
        sec7   = two_digit(i_digits[4], i_digits[5]);
        o_ok   = (hour7 <= HOUR_MAX) && (min7 <= MINSEC_MAX) &&
                 (sec7 <= MINSEC_MAX);
        o_hour = hour7[4:0];
        o_min  = min7[5:0];
        o_sec  = sec7[5:0];
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Drains the UART RX FIFO and turns bytes into control pulses / set-time loads.
// Ports: i_clk, i_rst_n, rx (FIFO read port), command pulses, set outputs, o_err, o_busy.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_cmd_sequencer_if.master rx,
    output logic                 o_run,
    output logic                 o_stop,
    output logic                 o_clear,
    output logic                 o_mode,
    output logic                 o_display_mode,
    output logic                 o_sec_plus,
    output logic                 o_min_plus,
    output logic                 o_hour_plus,
    output logic                 o_set_valid,
    output logic [4:0]           o_set_hour,
    output logic [5:0]           o_set_min,
    output logic [5:0]           o_set_sec,
    output logic                 o_err,
    output logic                 o_busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    cmd_pulse_t      cmd_q, cmd_d;
    logic            set_valid_q, set_valid_d;
    logic            err_q, err_d;
    logic [4:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [5:0][3:0] digits_q, digits_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             pop;
    logic [TMR_W-1:0] timer_inc;
    cmd_pulse_t       cmd_dec;
    logic [4:0]       chk_hour;
    logic [5:0]       chk_min;
    logic [5:0]       chk_sec;
    logic             chk_ok;

    set_time_checker u_chk (
        .i_digits (digits_q),
        .o_hour   (chk_hour),
        .o_min    (chk_min),
        .o_sec    (chk_sec),
        .o_ok     (chk_ok)
    );

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        cmd_d       = '0;
        set_valid_d = 1'b0;
        err_d       = 1'b0;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        // Timer counts cycles since the last pop; it stops one short of
        // TIMEOUT_CYC because the abort fires as that value is reached.
        timer_inc   = timer_q + 1'b1;
        cmd_dec     = decode_cmd(rx.rx_data);

        unique case (state_q)
            ST_IDLE: begin
                if (!rx.rx_empty && i_rst_n) begin
                    pop     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Pulses are registered here so they show up during EXEC.
                byte_d  = rx.rx_data;
                cmd_d   = cmd_dec;
                err_d   = (cmd_dec == '0) && (rx.rx_data != CH_T);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (byte_q == CH_T) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_SET_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET_WAIT: begin
                // A byte arriving on the expiry cycle still wins.
                if (!rx.rx_empty && i_rst_n) begin
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = ST_SET_FETCH;
                end else if (timer_inc == TMR_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_SET_FETCH: begin
                if (!is_digit(rx.rx_data)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < 6; i++) begin
                        if (cnt_q == 3'(i)) begin
                            digits_d[i] = rx.rx_data[3:0];
                        end
                    end
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = timer_inc;
                    if (cnt_q == 3'd5) begin
                        state_d = ST_SET_CHECK;
                    end else begin
                        state_d = ST_SET_WAIT;
                    end
                end
            end
            ST_SET_CHECK: begin
                if (chk_ok) begin
                    hour_d      = chk_hour;
                    min_d       = chk_min;
                    sec_d       = chk_sec;
                    set_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            byte_q      <= '0;
            cmd_q       <= '0;
            set_valid_q <= 1'b0;
            err_q       <= 1'b0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            cmd_q       <= cmd_d;
            set_valid_q <= set_valid_d;
            err_q       <= err_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            timer_q     <= timer_d;
        end
    end

    assign rx.rx_pop        = pop;
    assign o_run            = cmd_q.run;
    assign o_stop           = cmd_q.stop;
    assign o_clear          = cmd_q.clear;
    assign o_mode           = cmd_q.mode;
    assign o_display_mode   = cmd_q.disp;
    assign o_sec_plus       = cmd_q.sec_plus;
    assign o_min_plus       = cmd_q.min_plus;
    assign o_hour_plus      = cmd_q.hour_plus;
    assign o_set_valid      = set_valid_q;
    assign o_set_hour       = hour_q;
    assign o_set_min        = min_q;
    assign o_set_sec        = sec_q;
    assign o_err            = err_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a queue-backed RX FIFO model.
// Traces every cycle's outputs and checks them against hand-computed values.
module tb_uart_cmd_sequencer;

    logic clk;
    logic rst_n;

    logic run, stop, clr, mode, disp, secp, minp, hourp;
    logic setv, err, busy;
    logic [4:0] s_hour;
    logic [5:0] s_min;
    logic [5:0] s_sec;

    uart_cmd_sequencer_if rx_if ();

    uart_cmd_sequencer #(.TIMEOUT_CYC(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .rx             (rx_if),
        .o_run          (run),
        .o_stop         (stop),
        .o_clear        (clr),
        .o_mode         (mode),
        .o_display_mode (disp),
        .o_sec_plus     (secp),
        .o_min_plus     (minp),
        .o_hour_plus    (hourp),
        .o_set_valid    (setv),
        .o_set_hour     (s_hour),
        .o_set_min      (s_min),
        .o_set_sec      (s_sec),
        .o_err          (err),
        .o_busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int MAXC = 4096;

    // trace bits: 11 pop, 10 busy, 9 err, 8 set_valid, 7..0 commands
    // (run stop clear mode disp sec+ min+ hour+)
    logic [11:0] trace [MAXC];
    logic [16:0] hms   [MAXC];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  fifo [$];

    typedef struct {
        logic [7:0] b;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic popped;
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected <%0d", cyc, MAXC);
            $fatal(1);
        end
        trace[cyc] = {rx_if.rx_pop, busy, err, setv, run, stop, clr,
                      mode, disp, secp, minp, hourp};
        hms[cyc]   = {s_hour, s_min, s_sec};
        popped     = rx_if.rx_pop;
        cyc++;
        @(posedge clk);
        #1;
        if (popped && fifo.size() > 0) rx_if.rx_data = fifo.pop_front();
        rx_if.rx_empty = (fifo.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input string s);
        for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
        rx_if.rx_empty = (fifo.size() == 0);
    endtask

    function automatic logic [11:0] tr(input int i);
        if (i >= 0 && i < cyc) return trace[i];
        return 12'hfff;
    endfunction

    function automatic logic [9:0] pl(input int i);
        logic [11:0] t;
        t = tr(i);
        return t[9:0];
    endfunction

    function automatic logic bz(input int i);
        logic [11:0] t;
        t = tr(i);
        return t[10];
    endfunction

    function automatic logic [16:0] hv(input int i);
        if (i >= 0 && i < cyc) return hms[i];
        return 17'h1ffff;
    endfunction

    function automatic int find_pop(input int from);
        for (int i = (from < 0 ? 0 : from); i < cyc; i++)
            if (trace[i][11]) return i;
        return -1000;
    endfunction

    localparam logic [16:0] HMS_235907 = {5'd23, 6'd59, 6'd7};

    initial begin
        int st, p, p1, p2, q, r, cnt;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rx_if.rx_empty = 1'b1;
        rx_if.rx_data  = 8'h00;

        tbl[0] = '{8'h72, 10'h080};
        tbl[1] = '{8'h73, 10'h040};
        tbl[2] = '{8'h63, 10'h020};
        tbl[3] = '{8'h6d, 10'h010};
        tbl[4] = '{8'h64, 10'h008};
        tbl[5] = '{8'h53, 10'h004};
        tbl[6] = '{8'h4d, 10'h002};
        tbl[7] = '{8'h48, 10'h001};
        tbl[8] = '{8'h78, 10'h200};
        tbl[9] = '{8'h35, 10'h200};

        ticks(3);
        chk("reset_outputs", {20'h0, tr(2)}, 32'h0);
        chk("reset_set_vals", {15'h0, hv(2)}, 32'h0);
        rst_n = 1'b1;
        ticks(2);

        for (int v = 0; v < 10; v++) begin
            st = cyc;
            fifo.push_back(tbl[v].b);
            rx_if.rx_empty = 1'b0;
            ticks(6);
            p = find_pop(st);
            chk($sformatf("tbl%0d_pulse", v), {22'h0, pl(p + 2)},
                {22'h0, tbl[v].exp});
            chk($sformatf("tbl%0d_quiet", v), {12'h0, pl(p + 1), pl(p + 3)},
                32'h0);
        end

        st = cyc;
        push("rSc");
        ticks(14);
        p  = find_pop(st);
        p1 = find_pop(p + 1);
        p2 = find_pop(p1 + 1);
        chk("rsc_gap1", p1 - p, 3);
        chk("rsc_gap2", p2 - p1, 3);
        chk("rsc_run", {22'h0, pl(p + 2)}, 32'h080);
        chk("rsc_secp", {22'h0, pl(p1 + 2)}, 32'h004);
        chk("rsc_clear", {22'h0, pl(p2 + 2)}, 32'h020);
        cnt = 0;
        for (int i = st; i < cyc; i++) if (tr(i) & 12'h800) cnt++;
        chk("rsc_pop_count", cnt, 3);

        st = cyc;
        push("T235907");
        ticks(24);
        p = find_pop(st);
        chk("set_valid_at16", {22'h0, pl(p + 16)}, 32'h100);
        chk("set_quiet_at15", {22'h0, pl(p + 15)}, 32'h0);
        chk("set_values", {15'h0, hv(p + 16)}, {15'h0, HMS_235907});
        chk("set_hold", {15'h0, hv(p + 22)}, {15'h0, HMS_235907});

        st = cyc;
        push("T245900");
        ticks(22);
        p = find_pop(st);
        chk("range_err", {22'h0, pl(p + 16)}, 32'h200);
        chk("range_keep", {15'h0, hv(p + 20)}, {15'h0, HMS_235907});

        st = cyc;
        push("T12ar");
        ticks(16);
        p = find_pop(st);
        chk("digit_err", {22'h0, pl(p + 9)}, 32'h200);
        chk("digit_then_run", {22'h0, pl(p + 11)}, 32'h080);

        st = cyc;
        push("T12");
        ticks(30);
        p = find_pop(st);
        q = find_pop(find_pop(p + 1) + 1);
        chk("tmo_err", {22'h0, pl(q + 16)}, 32'h200);
        chk("tmo_busy_before", {31'h0, bz(q + 15)}, 32'h1);
        chk("tmo_busy_after", {31'h0, bz(q + 16)}, 32'h0);
        cnt = 0;
        for (int i = q + 1; i < q + 16; i++) if (pl(i) != 10'h0) cnt++;
        chk("tmo_quiet", cnt, 0);
        st = cyc;
        push("3");
        ticks(6);
        r = find_pop(st);
        chk("tmo_late_digit", {22'h0, pl(r + 2)}, 32'h200);

        st = cyc;
        push("T1");
        ticks(6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(4);
        chk("rst_mid_outputs", {20'h0, tr(st + 7)}, 32'h0);
        chk("rst_mid_set_vals", {15'h0, hv(st + 7)}, 32'h0);
        cnt = 0;
        for (int i = st; i < cyc; i++) if (tr(i) & 12'h200) cnt++;
        chk("rst_mid_no_err", cnt, 0);
        st = cyc;
        push("m");
        ticks(6);
        p = find_pop(st);
        chk("rst_then_mode", {22'h0, pl(p + 2)}, 32'h010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
